sram_dp_be: RTL and testbench

Parametrised simple-dual-port synchronous SRAM with one write port and one read port, both on the same clock. Each write is byte-masked, read latency is 1 or 2 cycles, read-during-write behaviour is selectable, and the array is cleared automatically after reset. It is the next-generation data/instruction memory for the pipelined CPU and replaces the single-port, fixed-16-bit, unresettable array. Fetch and load/store stages get independent ports.

---
 rtl/sram_dp_be.sv | 146 ++++++++++++++
 tb/tb_sram_dp_be.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_be.sv
// Simple-dual-port synchronous SRAM with byte-masked writes, a 1- or 2-cycle read pipeline,
// selectable read-during-write behaviour and an optional zeroing sweep after reset.
module sram_dp_be #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned DATA_DEPTH     = 4096,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned RDW_MODE       = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 we_n,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     wr_be,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]                data_in,
    input  logic                                 rd_en,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 rd_valid,
    output logic                                 init_busy
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    // Depth widened by one bit so DATA_DEPTH == 2^ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DATA_DEPTH - 1);

    typedef enum logic [0:0] {StReady, StClear} state_e;

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? StClear : StReady;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic                  ready;
    logic                  wr_in_range, rd_in_range;
    logic                  wr_fire, rd_fire;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  out_fire;
    logic [DATA_WIDTH-1:0] out_word;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    assign ready       = (state_q == StReady);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
    assign wr_fire     = ready && !we_n && wr_in_range;
    assign rd_fire     = ready && rd_en;
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];

    // Next-state logic: sweep clr_cnt through every word, then serve requests.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = StReady;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: state_d = StReady;
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage array: sweep writes zeros, otherwise byte-masked user writes.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word: zero when out of range, new lanes merged in write-first mode on a collision.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_idx];
            if ((RDW_MODE != 0) && wr_fire && (wr_addr == rd_addr)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) begin
                        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Latency 2 sources the output stage from the extra register stage.
    assign out_fire = (RD_LATENCY == 2) ? s1_valid_q : rd_fire;
    assign out_word = (RD_LATENCY == 2) ? s1_data_q : rd_word;

    // Read pipeline; data_out holds between completions, reset discards in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end
            rd_valid_q <= out_fire;
            if (out_fire) begin
                data_out_q <= out_word;
            end
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = (state_q == StClear);

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: two instances (latency 1 write-first, latency 2 read-first) share
// stimulus and are compared every cycle against an array/queue reference model.
module tb_sram_dp_be;

    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int BW    = 8;
    localparam int NB    = DW / BW;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          we_n = 1'b1;
    logic [NB-1:0] wr_be = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          vld_a, vld_b, busy_a, busy_b;

    always #5 clk = ~clk;

    sram_dp_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .DATA_DEPTH(DEPTH),
        .RD_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .we_n(we_n), .wr_be(wr_be), .wr_addr(wr_addr),
        .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_a),
        .rd_valid(vld_a), .init_busy(busy_a)
    );

    sram_dp_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .DATA_DEPTH(DEPTH),
        .RD_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .we_n(we_n), .wr_be(wr_be), .wr_addr(wr_addr),
        .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_b),
        .rd_valid(vld_b), .init_busy(busy_b)
    );

    // Reference model state.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic [DW-1:0] ref_mem [DEPTH];
    rd_t           q_a[$];
    rd_t           q_b[$];
    int            clr_left = 0;
    int            cyc = 0;
    logic [DW-1:0] exp_dout_a = '0, exp_dout_b = '0;
    logic          exp_vld_a = 1'b0, exp_vld_b = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] read_word(input int addr, input bit write_first);
        logic [DW-1:0] w;
        if (addr >= DEPTH) return '0;
        w = ref_mem[addr];
        if (write_first && !we_n && int'(wr_addr) == addr) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) w[i*BW +: BW] = data_in[i*BW +: BW];
            end
        end
        return w;
    endfunction

    // Applies one rising edge's worth of behaviour to the model.
    task automatic model_edge();
        rd_t e;
        int  wa;
        cyc++;
        if (clr_left > 0) begin
            ref_mem[DEPTH - clr_left] = '0;
            clr_left--;
        end else begin
            if (rd_en) begin
                e.data = read_word(int'(rd_addr), 1'b1);
                e.due  = cyc;
                q_a.push_back(e);
                e.data = read_word(int'(rd_addr), 1'b0);
                e.due  = cyc + 1;
                q_b.push_back(e);
            end
            wa = int'(wr_addr);
            if (!we_n && wa < DEPTH) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) ref_mem[wa][i*BW +: BW] = data_in[i*BW +: BW];
                end
            end
        end
        exp_vld_a = 1'b0;
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
            exp_dout_a = q_a[0].data;
            exp_vld_a  = 1'b1;
            void'(q_a.pop_front());
        end
        exp_vld_b = 1'b0;
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
            exp_dout_b = q_b[0].data;
            exp_vld_b  = 1'b1;
            void'(q_b.pop_front());
        end
    endtask

    task automatic compare_all();
        check_eq("dout_a", dout_a, exp_dout_a);
        check_eq("vld_a",  vld_a,  exp_vld_a);
        check_eq("busy_a", busy_a, clr_left > 0);
        check_eq("dout_b", dout_b, exp_dout_b);
        check_eq("vld_b",  vld_b,  exp_vld_b);
        check_eq("busy_b", busy_b, clr_left > 0);
    endtask

    // One clock: inputs are already set; advance model at the edge and compare #1 later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        we_n  = 1'b1;
        rd_en = 1'b0;
        wr_be = '0;
    endtask

    task automatic rand_inputs();
        we_n    = 1'($urandom_range(0, 1));
        wr_be   = NB'($urandom);
        wr_addr = AW'($urandom_range(0, 19));
        data_in = DW'($urandom);
        rd_en   = ($urandom_range(0, 9) < 6);
        rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 19));
    endtask

    task automatic do_write(input int addr, input logic [DW-1:0] data, input logic [NB-1:0] be);
        we_n    = 1'b0;
        wr_addr = AW'(addr);
        data_in = data;
        wr_be   = be;
        rd_en   = 1'b0;
        cycle();
        set_idle();
    endtask

    // Called just after a rising edge; asserts reset mid-cycle, releases it after the next edge.
    task automatic reset_dut();
        #2 rst_n = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        exp_dout_a = '0;
        exp_dout_b = '0;
        exp_vld_a  = 1'b0;
        exp_vld_b  = 1'b0;
        clr_left   = DEPTH;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    // Runs the sweep under random (ignored) requests and checks its length.
    task automatic measure_clear(input string tag);
        int n = 0;
        for (int i = 0; i < 40 && busy_a; i++) begin
            rand_inputs();
            cycle();
            n++;
        end
        set_idle();
        check_eq(tag, n, DEPTH);
    endtask

    task automatic read_all_zero(input string tag);
        int va = 0;
        int vb = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            cycle();
            if (vld_a) va++;
            if (vld_b) vb++;
        end
        set_idle();
        cycle();
        if (vld_b) vb++;
        check_eq({tag, "_cnt_a"}, va, DEPTH);
        check_eq({tag, "_cnt_b"}, vb, DEPTH);
    endtask

    initial begin
        // Power-on reset.
        #2;
        reset_dut();
        measure_clear("clear_len");
        read_all_zero("clear_rd");

        // Byte mask.
        do_write(5, 16'hABCD, 2'b11);
        do_write(5, 16'h1234, 2'b01);
        rd_en = 1'b1; rd_addr = AW'(5);
        cycle();
        set_idle();
        check_eq("bytemask_a", dout_a, 16'hAB34);
        cycle();
        check_eq("bytemask_b", dout_b, 16'hAB34);

        // Back-to-back reads through the 2-stage pipeline.
        do_write(1, 16'h0011, 2'b11);
        do_write(2, 16'h0022, 2'b11);
        do_write(3, 16'h0033, 2'b11);
        rd_en = 1'b1; rd_addr = AW'(1);
        cycle();
        check_eq("lat_b_first_idle", vld_b, 1'b0);
        rd_addr = AW'(2);
        cycle();
        check_eq("lat_b_d1", dout_b, 16'h0011);
        check_eq("lat_b_v1", vld_b, 1'b1);
        rd_addr = AW'(3);
        cycle();
        check_eq("lat_b_d2", dout_b, 16'h0022);
        set_idle();
        cycle();
        check_eq("lat_b_d3", dout_b, 16'h0033);
        check_eq("lat_b_v3", vld_b, 1'b1);
        cycle();
        check_eq("lat_b_drop", vld_b, 1'b0);
        check_eq("lat_b_hold", dout_b, 16'h0033);

        // Read during write to the same address.
        do_write(7, 16'h5555, 2'b11);
        we_n = 1'b0; wr_addr = AW'(7); data_in = 16'hAAAA; wr_be = 2'b10;
        rd_en = 1'b1; rd_addr = AW'(7);
        cycle();
        set_idle();
        check_eq("rdw_wf_a", dout_a, 16'hAA55);
        cycle();
        check_eq("rdw_rf_b", dout_b, 16'h5555);
        rd_en = 1'b1; rd_addr = AW'(7);
        cycle();
        set_idle();
        check_eq("rdw_after_a", dout_a, 16'hAA55);
        cycle();
        check_eq("rdw_after_b", dout_b, 16'hAA55);

        // Out of range: address 20 must not alias onto address 4.
        do_write(4, 16'h4444, 2'b11);
        do_write(20, 16'hFFFF, 2'b11);
        rd_en = 1'b1; rd_addr = AW'(20);
        cycle();
        check_eq("oor_d_a", dout_a, 16'h0000);
        check_eq("oor_v_a", vld_a, 1'b1);
        rd_addr = AW'(4);
        cycle();
        set_idle();
        check_eq("oor_d_b", dout_b, 16'h0000);
        check_eq("oor_v_b", vld_b, 1'b1);
        check_eq("oor_keep_a", dout_a, 16'h4444);
        cycle();
        check_eq("oor_keep_b", dout_b, 16'h4444);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        // Reset with reads in flight, then again mid-sweep at clr_cnt=9.
        rd_en = 1'b1; rd_addr = AW'(5);
        cycle();
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            rand_inputs();
            cycle();
        end
        reset_dut();
        measure_clear("clear_len_restart");
        read_all_zero("restart_rd");

        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
